// File: rtl/exe_stage.sv
// RV32I execute stage: single-cycle ALU, branch resolution and AUIPC, plus an
// iterative shifter that holds the upstream pipeline until the shift completes.
module exe_stage #(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        flush,
    output logic        stall,
    input  logic [1:0]  CRT_WB_IN,
    input  logic [2:0]  CRT_MEM_IN,
    input  logic [2:0]  CRT_EXE_IN,
    input  logic [31:0] PC_IN,
    input  logic [31:0] DATA_A_IN,
    input  logic [31:0] DATA_B_IN,
    input  logic [31:0] DATA_SE_IN,
    input  logic [4:0]  INST_IN,
    input  logic [6:0]  FUNCT7_IN,
    input  logic [2:0]  FUNCT3_IN,
    output logic        valid_out,
    output logic [1:0]  CRT_WB_OUT,
    output logic [2:0]  CRT_MEM_OUT,
    output logic [4:0]  RD_OUT,
    output logic [31:0] ALU_RESULT_OUT,
    output logic [31:0] STORE_DATA_OUT,
    output logic        BRANCH_TAKEN_OUT,
    output logic [31:0] BRANCH_TARGET_OUT
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [4:0] STEP = 5'(SHIFT_PER_CYCLE);

    state_t      state;
    state_t      state_next;

    logic [1:0]  alu_op;
    logic        alu_src;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        is_shift;
    logic [31:0] alu_result;
    logic        branch_cond;
    logic        accept;
    logic        start_shift;

    logic [31:0] work;
    logic [4:0]  remaining;
    logic        shift_right;
    logic        shift_fill;
    logic [4:0]  step;
    logic [31:0] shifted;
    logic        shift_done;

    logic [1:0]  pend_wb;
    logic [2:0]  pend_mem;
    logic [4:0]  pend_rd;
    logic [31:0] pend_store;

    logic        unused_funct7;

    assign alu_op        = CRT_EXE_IN[2:1];
    assign alu_src       = CRT_EXE_IN[0];
    assign op_b          = alu_src ? DATA_SE_IN : DATA_B_IN;
    assign shamt         = op_b[4:0];
    assign is_shift      = (alu_op == 2'b10) && (FUNCT3_IN[1:0] == 2'b01);
    assign accept        = (state == IDLE) && valid_in && !flush;
    assign start_shift   = accept && is_shift && (shamt != 5'd0);
    assign stall         = (state == SHIFT);
    assign unused_funct7 = ^{FUNCT7_IN[6], FUNCT7_IN[4:0]};

    // The final iteration may move fewer bits than SHIFT_PER_CYCLE.
    assign step       = (remaining < STEP) ? remaining : STEP;
    assign shift_done = (remaining <= STEP);
    assign shifted    = shift_right ? 32'({{8{shift_fill}}, work} >> step)
                                    : (work << step);

    // Single-cycle result; shift codes land here only for shamt = 0, which returns A.
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            2'b00: alu_result = DATA_A_IN + op_b;
            2'b01: alu_result = PC_IN + 32'd4;
            2'b10: begin
                case (FUNCT3_IN)
                    3'b000: alu_result = (FUNCT7_IN[5] && !alu_src) ? DATA_A_IN - op_b
                                                                    : DATA_A_IN + op_b;
                    3'b010: alu_result = {31'd0, $signed(DATA_A_IN) < $signed(op_b)};
                    3'b011: alu_result = {31'd0, DATA_A_IN < op_b};
                    3'b100: alu_result = DATA_A_IN ^ op_b;
                    3'b110: alu_result = DATA_A_IN | op_b;
                    3'b111: alu_result = DATA_A_IN & op_b;
                    default: alu_result = DATA_A_IN;
                endcase
            end
            default: alu_result = PC_IN + DATA_SE_IN;
        endcase
    end

    always_comb begin
        branch_cond = 1'b0;
        case (FUNCT3_IN)
            3'b000: branch_cond = (DATA_A_IN == DATA_B_IN);
            3'b001: branch_cond = (DATA_A_IN != DATA_B_IN);
            3'b100: branch_cond = ($signed(DATA_A_IN) <  $signed(DATA_B_IN));
            3'b101: branch_cond = ($signed(DATA_A_IN) >= $signed(DATA_B_IN));
            3'b110: branch_cond = (DATA_A_IN <  DATA_B_IN);
            3'b111: branch_cond = (DATA_A_IN >= DATA_B_IN);
            default: branch_cond = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        if (flush)
            state_next = IDLE;
        else if ((state == IDLE) && start_shift)
            state_next = SHIFT;
        else if ((state == SHIFT) && shift_done)
            state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Flush kills both a fresh bundle and a shift in flight; data outputs keep their values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out         <= 1'b0;
            CRT_WB_OUT        <= 2'd0;
            CRT_MEM_OUT       <= 3'd0;
            RD_OUT            <= 5'd0;
            ALU_RESULT_OUT    <= 32'd0;
            STORE_DATA_OUT    <= 32'd0;
            BRANCH_TAKEN_OUT  <= 1'b0;
            BRANCH_TARGET_OUT <= 32'd0;
            work              <= 32'd0;
            remaining         <= 5'd0;
            shift_right       <= 1'b0;
            shift_fill        <= 1'b0;
            pend_wb           <= 2'd0;
            pend_mem          <= 3'd0;
            pend_rd           <= 5'd0;
            pend_store        <= 32'd0;
        end else if (flush) begin
            valid_out        <= 1'b0;
            BRANCH_TAKEN_OUT <= 1'b0;
        end else if (state == IDLE) begin
            valid_out        <= 1'b0;
            BRANCH_TAKEN_OUT <= 1'b0;
            if (start_shift) begin
                work        <= DATA_A_IN;
                remaining   <= shamt;
                shift_right <= FUNCT3_IN[2];
                shift_fill  <= FUNCT7_IN[5] & DATA_A_IN[31];
                pend_wb     <= CRT_WB_IN;
                pend_mem    <= CRT_MEM_IN;
                pend_rd     <= INST_IN;
                pend_store  <= DATA_B_IN;
            end else if (valid_in) begin
                valid_out         <= 1'b1;
                CRT_WB_OUT        <= CRT_WB_IN;
                CRT_MEM_OUT       <= CRT_MEM_IN;
                RD_OUT            <= INST_IN;
                ALU_RESULT_OUT    <= alu_result;
                STORE_DATA_OUT    <= DATA_B_IN;
                BRANCH_TAKEN_OUT  <= (alu_op == 2'b01) && branch_cond;
                BRANCH_TARGET_OUT <= PC_IN + DATA_SE_IN;
            end
        end else begin
            work             <= shifted;
            remaining        <= remaining - step;
            valid_out        <= 1'b0;
            BRANCH_TAKEN_OUT <= 1'b0;
            if (shift_done) begin
                valid_out      <= 1'b1;
                CRT_WB_OUT     <= pend_wb;
                CRT_MEM_OUT    <= pend_mem;
                RD_OUT         <= pend_rd;
                ALU_RESULT_OUT <= shifted;
                STORE_DATA_OUT <= pend_store;
            end
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: one instance with 1-bit shift steps and one with
// 8-bit steps, both fed the same instruction stream.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  crt_wb = 2'd0;
    logic [2:0]  crt_mem = 3'd0;
    logic [2:0]  crt_exe = 3'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] data_a = 32'd0;
    logic [31:0] data_b = 32'd0;
    logic [31:0] data_se = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [2:0]  funct3 = 3'd0;

    logic        stall, valid_out, taken;
    logic [1:0]  wb_out;
    logic [2:0]  mem_out;
    logic [4:0]  rd_out;
    logic [31:0] result, store_out, target;

    logic        stall8, valid8, taken8;
    logic [1:0]  wb8;
    logic [2:0]  mem8;
    logic [4:0]  rd8;
    logic [31:0] result8, store8, target8;

    int errors = 0;
    int checks = 0;
    int cnt;
    int cnt8;

    always #5 clk = ~clk;

    exe_stage #(.SHIFT_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .stall(stall),
        .CRT_WB_IN(crt_wb), .CRT_MEM_IN(crt_mem), .CRT_EXE_IN(crt_exe),
        .PC_IN(pc), .DATA_A_IN(data_a), .DATA_B_IN(data_b), .DATA_SE_IN(data_se),
        .INST_IN(rd), .FUNCT7_IN(funct7), .FUNCT3_IN(funct3),
        .valid_out(valid_out), .CRT_WB_OUT(wb_out), .CRT_MEM_OUT(mem_out),
        .RD_OUT(rd_out), .ALU_RESULT_OUT(result), .STORE_DATA_OUT(store_out),
        .BRANCH_TAKEN_OUT(taken), .BRANCH_TARGET_OUT(target)
    );

    exe_stage #(.SHIFT_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .stall(stall8),
        .CRT_WB_IN(crt_wb), .CRT_MEM_IN(crt_mem), .CRT_EXE_IN(crt_exe),
        .PC_IN(pc), .DATA_A_IN(data_a), .DATA_B_IN(data_b), .DATA_SE_IN(data_se),
        .INST_IN(rd), .FUNCT7_IN(funct7), .FUNCT3_IN(funct3),
        .valid_out(valid8), .CRT_WB_OUT(wb8), .CRT_MEM_OUT(mem8),
        .RD_OUT(rd8), .ALU_RESULT_OUT(result8), .STORE_DATA_OUT(store8),
        .BRANCH_TAKEN_OUT(taken8), .BRANCH_TARGET_OUT(target8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one bundle for a single edge; returns 1 time unit after that edge.
    task automatic applyStimulus(input logic [1:0] op, input logic src, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] se, input logic [31:0] pc_v);
        crt_exe  = {op, src};
        funct3   = f3;
        funct7   = f7;
        data_a   = a;
        data_b   = b;
        data_se  = se;
        pc       = pc_v;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset valid_out", valid_out, 0);
        checkOutput("reset stall", stall, 0);
        checkOutput("reset result", result, 0);
        checkOutput("reset taken", taken, 0);
        rst = 1'b0;

        crt_wb = 2'b10; crt_mem = 3'b101; rd = 5'd7;
        applyStimulus(2'b10, 1'b0, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0);
        checkOutput("add valid", valid_out, 1);
        checkOutput("add result", result, 32'd12);
        checkOutput("add stall", stall, 0);
        checkOutput("add wb", wb_out, 2'b10);
        checkOutput("add mem", mem_out, 3'b101);
        checkOutput("add rd", rd_out, 5'd7);
        checkOutput("add store", store_out, 32'd7);

        applyStimulus(2'b10, 1'b0, 3'b000, 7'h20, 32'd3, 32'd5, 32'd0, 32'd0);
        checkOutput("sub result", result, 32'hFFFF_FFFE);
        applyStimulus(2'b10, 1'b1, 3'b000, 7'h20, 32'd3, 32'd99, 32'd5, 32'd0);
        checkOutput("addi result", result, 32'd8);

        // back-to-back logic and compare ops
        applyStimulus(2'b10, 1'b0, 3'b100, 7'h00, 32'hF0F0_0000, 32'h0FF0_00FF, 32'd0, 32'd0);
        checkOutput("xor result", result, 32'hFF00_00FF);
        checkOutput("xor valid", valid_out, 1);
        applyStimulus(2'b10, 1'b0, 3'b110, 7'h00, 32'h0000_0F00, 32'h0000_00F0, 32'd0, 32'd0);
        checkOutput("or result", result, 32'h0000_0FF0);
        applyStimulus(2'b10, 1'b0, 3'b111, 7'h00, 32'hFFFF_0000, 32'h00FF_FF00, 32'd0, 32'd0);
        checkOutput("and result", result, 32'h00FF_0000);
        applyStimulus(2'b10, 1'b0, 3'b010, 7'h00, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        checkOutput("slt result", result, 32'd1);
        applyStimulus(2'b10, 1'b0, 3'b011, 7'h00, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        checkOutput("sltu result", result, 32'd0);
        checkOutput("sltu valid", valid_out, 1);
        idleCycle();
        checkOutput("idle valid", valid_out, 0);

        applyStimulus(2'b11, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0, 32'h0000_3000, 32'h0000_0040);
        checkOutput("auipc result", result, 32'h0000_3040);
        applyStimulus(2'b00, 1'b1, 3'b010, 7'h00, 32'h0000_1000, 32'd0, 32'hFFFF_FFFC, 32'd0);
        checkOutput("addr result", result, 32'h0000_0FFC);

        // SRAI by 31 on both shifter widths
        applyStimulus(2'b10, 1'b1, 3'b101, 7'h20, 32'h8000_0000, 32'd0, 32'h0000_041F, 32'd0);
        cnt = 0;
        cnt8 = 0;
        for (int i = 0; i < 100; i++) begin
            if (stall) cnt++;
            if (stall8) cnt8++;
            if (!stall && !stall8) break;
            idleCycle();
        end
        checkOutput("sra stall cycles", cnt, 31);
        checkOutput("sra8 stall cycles", cnt8, 4);
        checkOutput("sra valid", valid_out, 1);
        checkOutput("sra result", result, 32'hFFFF_FFFF);
        checkOutput("sra8 result", result8, 32'hFFFF_FFFF);

        applyStimulus(2'b01, 1'b0, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
        checkOutput("blt taken", taken, 1);
        checkOutput("blt target", target, 32'h120);
        checkOutput("blt result", result, 32'h104);
        applyStimulus(2'b01, 1'b0, 3'b110, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
        checkOutput("bltu taken", taken, 0);
        applyStimulus(2'b01, 1'b0, 3'b000, 7'h00, 32'd9, 32'd9, 32'h40, 32'h200);
        checkOutput("beq taken", taken, 1);
        idleCycle();
        checkOutput("taken clears", taken, 0);

        // SLLI by 20 flushed during its fifth shift cycle
        applyStimulus(2'b10, 1'b1, 3'b001, 7'h00, 32'd1, 32'd0, 32'd20, 32'd0);
        checkOutput("sll stall", stall, 1);
        repeat (4) idleCycle();
        checkOutput("sll still stalled", stall, 1);
        flush = 1'b1;
        idleCycle();
        flush = 1'b0;
        checkOutput("flush stall", stall, 0);
        checkOutput("flush valid", valid_out, 0);
        idleCycle();
        checkOutput("post flush valid", valid_out, 0);
        applyStimulus(2'b10, 1'b0, 3'b000, 7'h00, 32'd100, 32'd23, 32'd0, 32'd0);
        checkOutput("add after flush", result, 32'd123);
        checkOutput("add after flush valid", valid_out, 1);

        flush = 1'b1;
        applyStimulus(2'b10, 1'b0, 3'b000, 7'h00, 32'd1, 32'd1, 32'd0, 32'd0);
        flush = 1'b0;
        checkOutput("flushed add valid", valid_out, 0);
        checkOutput("flushed add holds", result, 32'd123);

        // reset in the middle of an SRL by 10
        applyStimulus(2'b10, 1'b0, 3'b101, 7'h00, 32'hFFFF_0000, 32'd10, 32'd0, 32'd0);
        repeat (3) idleCycle();
        checkOutput("srl stall", stall, 1);
        rst = 1'b1;
        #1;
        checkOutput("midreset stall", stall, 0);
        checkOutput("midreset valid", valid_out, 0);
        checkOutput("midreset result", result, 0);
        checkOutput("midreset rd", rd_out, 0);
        checkOutput("midreset wb", wb_out, 0);
        checkOutput("midreset store", store_out, 0);
        checkOutput("midreset target", target, 0);
        idleCycle();
        rst = 1'b0;
        idleCycle();
        checkOutput("after reset valid", valid_out, 0);
        applyStimulus(2'b10, 1'b1, 3'b001, 7'h00, 32'h0000_1234, 32'd0, 32'd0, 32'd0);
        checkOutput("shamt0 stall", stall, 0);
        checkOutput("shamt0 valid", valid_out, 1);
        checkOutput("shamt0 result", result, 32'h0000_1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
